// File: rtl/fls_pkg.sv
// Shared definitions for the FLS lab: phase encoding used by every
// block that produces or decodes the operand-entry / generation phase.
package fls_pkg;

  // Phase codes; display logic decodes these identically everywhere.
  typedef enum logic [1:0] {
    PH_LOAD0 = 2'd0,
    PH_LOAD1 = 2'd1,
    PH_RUN   = 2'd2,
    PH_BAD   = 2'd3
  } phase_e;

endpackage

// File: rtl/fls_btn_pulse.sv
// Button front end: synchronizes an asynchronous button level into the
// clock domain and turns each rising edge into a single-cycle pulse.
module fls_btn_pulse #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_q;

  // Synchronizer chain plus one edge-history flop behind its last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      en_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], en_i};
      en_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_o = sync_q[SYNC_STAGES-1] & ~en_q;

endmodule

// File: rtl/fls_term_tx.sv
// FLS transmit side: loads two seed operands from the switches, then
// generates f(n)=f(n-1)+f(n-2) on each press, and offers every accepted
// operand or term through a one-entry valid/ready output slot.
module fls_term_tx
  import fls_pkg::*;
#(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       phase,
  output logic             ovf,
  output logic             drop
);

  logic             press;
  logic             blocked;
  logic [WIDTH:0]   sum;

  phase_e           phase_q, phase_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;

  fls_btn_pulse #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .press_o(press)
  );

  // A same-cycle handshake empties the slot, so only valid-without-ready blocks.
  assign blocked = valid_q && !out_ready;
  assign sum     = {1'b0, a_q} + {1'b0, b_q};

  // Next-state for the phase FSM, operand registers and output slot.
  always_comb begin
    phase_d = phase_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (phase_q == PH_BAD) begin
      phase_d = PH_LOAD0;
    end else if (press && blocked) begin
      drop_d = 1'b1;
    end else if (press) begin
      valid_d = 1'b1;
      case (phase_q)
        PH_LOAD0: begin
          a_d     = d;
          data_d  = d;
          phase_d = PH_LOAD1;
        end
        PH_LOAD1: begin
          b_d     = d;
          data_d  = d;
          phase_d = PH_RUN;
        end
        default: begin
          a_d    = b_q;
          b_d    = sum[WIDTH-1:0];
          data_d = sum[WIDTH-1:0];
          ovf_d  = ovf_q | sum[WIDTH];
        end
      endcase
    end
  end

  // State register; reset acts immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_LOAD0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign phase     = phase_q;
  assign ovf       = ovf_q;
  assign drop      = drop_q;

endmodule
